remote_comm: RTL and testbench
==============================

Name: remote_comm

Overview:
- Host-side bluetooth-module model: serializes a 16-bit command as two 8N1 UART bytes on TX, then receives one-byte responses on RX.
- Sits in the system bench opposite the maze-runner controller. TX drives the runner's RX; runner's TX drives this block's RX.
- Typical exchange: send a command, wait for a 0xA5 acknowledge.

Parameters:
- BAUD_DIV, 2604, clocks per UART bit (19200 baud at 50 MHz); legal range 16..4095.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- RX  input  1  serial response from the runner; asynchronous, idle high
- TX  output  1  serial command to the runner; idle high
- cmd  input  16  command word; sampled when send_cmd is accepted
- send_cmd  input  1  one-cycle request to transmit cmd
- cmd_sent  output  1  both command bytes fully transmitted
- resp_rdy  output  1  response byte available
- resp  output  8  last received response byte

Behaviour:
- Reset values: TX=1, cmd_sent=0, resp_rdy=0, resp=8'h00; both FSMs idle. Reset mid-frame aborts the frame immediately and TX returns high next cycle.
- Transmit FSM states:
  - IDLE: on send_cmd, latch cmd into a 16-bit holding register, clear cmd_sent, go to HIGH.
  - HIGH: send cmd[15:8].
  - LOW: send cmd[7:0].
  - DONE: set cmd_sent, return to IDLE.
- Byte framing: start bit 0, data LSB first, one stop bit 1. Each bit lasts exactly BAUD_DIV clocks. 10 bit times per byte; no idle gap between the high and low byte.
- Latency: send_cmd sampled at edge N; TX start bit begins at edge N+1. cmd_sent rises at edge N+1+20*BAUD_DIV and stays high until the next accepted send_cmd.
- send_cmd while the transmit FSM is not in IDLE is ignored; no queueing, and the latched cmd is not altered.
- cmd changing after acceptance has no effect on the frame in flight.
- Receive path:
  - RX passes through a 2-flop synchronizer set to 1 at reset.
  - A falling edge in idle starts a frame.
  - Start bit is re-checked at BAUD_DIV/2 clocks; if high, treat as a glitch and return to idle.
  - Data bits are sampled at BAUD_DIV-spaced mid-bit points, LSB first, then the stop bit.
- Valid stop bit (1): resp updates with the byte and resp_rdy sets on the cycle after the stop-bit sample.
- Invalid stop bit (0): frame discarded; resp and resp_rdy unchanged. Receiver then waits for RX high before re-arming.
- resp_rdy clears on the cycle a new start bit is detected, or on an accepted send_cmd, whichever comes first. resp holds its value until the next valid byte.
- Transmit and receive are fully independent. Simultaneous send_cmd and a received byte completing are both honoured in the same cycle; in that case resp_rdy ends 1 and send_cmd's clear is overridden.
- Baud counters are 12 bits, reload on each bit boundary, and never wrap mid-bit.

Test Plan:
- Reset: hold rst 3 cycles -> TX=1, cmd_sent=0, resp_rdy=0, resp=8'h00.
- Command serialization (BAUD_DIV=16, cmd=16'h23FF, send_cmd pulse):
  - TX shows 0,11000100,1 then 0,11111111,1.
  - Each bit lasts 16 clocks.
  - cmd_sent rises exactly 321 cycles after the send_cmd edge.
- Busy rejection: second send_cmd with cmd=16'h4002 during the first frame -> ignored; transmitted bytes remain 0x23,0xFF; cmd_sent rises once.
- Response receive: drive RX with a serial 0xA5 at BAUD_DIV=16 -> resp_rdy rises after the stop-bit sample with resp=8'hA5. Then send_cmd=16'h0000 -> resp_rdy clears; resp stays 8'hA5.
- Error cases:
  - 4-clock RX low glitch -> no reception.
  - Byte 0x5A with stop bit 0 -> resp_rdy stays 0 and resp unchanged.
  - A following valid 0x3C -> resp=8'h3C.
- Loopback: TX tied to RX, send 16'h6000 -> resp_rdy pulses twice, with resp=8'h60 then 8'h00; cmd_sent=1 at end. Assert rst mid-second-byte -> TX=1 next cycle and cmd_sent=0.

Source files
------------

// File: rtl/remote_comm.sv
// Host-side UART command/response endpoint: sends a 16-bit command as two
// 8N1 bytes (high byte first) and receives single-byte responses.
module remote_comm #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    localparam logic [11:0] BIT_LAST  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_HIGH = 2'd1;
    localparam logic [1:0] TX_LOW  = 2'd2;
    localparam logic [1:0] TX_DONE = 2'd3;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;

    logic [1:0]  tx_state;
    logic [11:0] tx_cnt;
    logic [3:0]  tx_idx;
    logic [15:0] cmd_hold;
    logic [7:0]  tx_byte;
    logic [9:0]  tx_frame;
    logic        tx_bit;
    logic        tx_q;
    logic        send_ok;

    logic        rx_p0;
    logic        rx_p1;
    logic [2:0]  rx_state;
    logic [11:0] rx_cnt;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shift;
    logic        rx_start;
    logic        rx_done;

    assign send_ok = send_cmd && (tx_state == TX_IDLE);
    assign TX      = tx_q;

    always_comb begin
        tx_byte  = (tx_state == TX_HIGH) ? cmd_hold[15:8] : cmd_hold[7:0];
        tx_frame = {1'b1, tx_byte, 1'b0};
        tx_bit   = 1'b1;
        if (tx_state == TX_HIGH || tx_state == TX_LOW)
            tx_bit = tx_frame[tx_idx];
    end

    // TX output is registered, so the line lags the state by one clock: the
    // start bit appears the edge after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_q     <= 1'b1;
            cmd_sent <= 1'b0;
        end else begin
            tx_q <= tx_bit;
            case (tx_state)
                TX_IDLE: begin
                    if (send_cmd) begin
                        cmd_sent <= 1'b0;
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_state <= TX_HIGH;
                    end
                end
                TX_HIGH, TX_LOW: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 4'd9) begin
                            tx_idx   <= '0;
                            tx_state <= (tx_state == TX_HIGH) ? TX_LOW : TX_DONE;
                        end else begin
                            tx_idx <= tx_idx + 4'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 12'd1;
                    end
                end
                default: begin
                    cmd_sent <= 1'b1;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (send_ok)
            cmd_hold <= cmd;
    end

    // Receive side: two-flop synchronizer, idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= RX;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_start = (rx_state == RX_IDLE) && !rx_p1;
    assign rx_done  = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_p1) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_p1 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 12'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        rx_idx <= rx_idx + 3'd1;
                        if (rx_idx == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 12'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_p1 ? RX_IDLE : RX_WAIT;
                    end else begin
                        rx_cnt <= rx_cnt + 12'd1;
                    end
                end
                RX_WAIT: begin
                    // Framing error: hold off until the line returns high.
                    if (rx_p1)
                        rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == RX_DATA && rx_cnt == BIT_LAST)
            rx_shift <= {rx_p1, rx_shift[7:1]};
    end

    // A completing byte wins over the clear from a same-cycle send_cmd.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp     <= 8'h00;
            resp_rdy <= 1'b0;
        end else begin
            if (rx_done) begin
                resp     <= rx_shift;
                resp_rdy <= 1'b1;
            end else if (rx_start || send_ok) begin
                resp_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_remote_comm.sv
// Randomized self-checking bench for remote_comm against a bit-level
// reference of the UART frames and response bookkeeping.
module tb_remote_comm;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx;
    logic        rx_line;
    logic        rx_drive;
    logic        loopback;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_resp;
    logic       exp_rdy;

    assign rx_line = loopback ? tx : rx_drive;

    remote_comm #(.BAUD_DIV(BD)) dut (
        .clk      (clk),
        .rst      (rst),
        .RX       (rx_line),
        .TX       (tx),
        .cmd      (cmd),
        .send_cmd (send_cmd),
        .cmd_sent (cmd_sent),
        .resp_rdy (resp_rdy),
        .resp     (resp)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send c; optionally fire a rejected send of c2 at cycle busy_at of the frame.
    task automatic send_and_check(input logic [15:0] c, input int busy_at, input logic [15:0] c2);
        logic [19:0] frame;
        int match;
        int idle_ok;
        frame[0]  = 1'b0;
        frame[9]  = 1'b1;
        frame[10] = 1'b0;
        frame[19] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            frame[1 + i]  = c[8 + i];
            frame[11 + i] = c[i];
        end
        cmd      = c;
        send_cmd = 1'b1;
        tick();
        send_cmd = 1'b0;
        exp_rdy  = 1'b0;
        check_val("tx_idle_at_accept", tx, 1'b1);
        check_val("cmd_sent_cleared", cmd_sent, 1'b0);
        match = 0;
        for (int t = 1; t <= 20 * BD; t++) begin
            tick();
            if (t == 1) begin
                check_val("rdy_cleared_by_send", resp_rdy, exp_rdy);
                check_val("resp_held_on_send", resp, exp_resp);
            end
            if (tx === frame[(t - 1) / BD])
                match++;
            if ((t - 1) % BD == BD - 1) begin
                check_val($sformatf("tx_bit%0d_cycles", (t - 1) / BD), match, BD);
                match = 0;
            end
            if (t == 20 * BD)
                check_val("cmd_sent_not_early", cmd_sent, 1'b0);
            cmd      = 16'($urandom);
            send_cmd = 1'b0;
            if (t == busy_at) begin
                cmd      = c2;
                send_cmd = 1'b1;
            end
        end
        send_cmd = 1'b0;
        tick();
        check_val("cmd_sent_rise", cmd_sent, 1'b1);
        idle_ok = 0;
        for (int t = 0; t < 3 * BD; t++) begin
            if (tx === 1'b1 && cmd_sent === 1'b1)
                idle_ok++;
            tick();
        end
        check_val("idle_after_frame", idle_ok, 3 * BD);
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            if (k == 0)
                exp_rdy = 1'b0;
            if (k == 3)
                check_val("rdy_cleared_by_start", resp_rdy, exp_rdy);
            rx_drive = f[k];
            repeat (BD) tick();
        end
        rx_drive = 1'b1;
        repeat (BD) tick();
        if (stop) begin
            exp_resp = b;
            exp_rdy  = 1'b1;
        end
        check_val(stop ? "rx_rdy" : "rx_rdy_badstop", resp_rdy, exp_rdy);
        check_val(stop ? "rx_resp" : "rx_resp_badstop", resp, exp_resp);
    endtask

    initial begin
        logic [7:0] got_q[$];
        logic       prev;
        rst      = 1'b1;
        send_cmd = 1'b0;
        cmd      = 16'h0000;
        rx_drive = 1'b1;
        loopback = 1'b0;
        repeat (3) tick();
        check_val("reset_tx", tx, 1'b1);
        check_val("reset_cmd_sent", cmd_sent, 1'b0);
        check_val("reset_resp_rdy", resp_rdy, 1'b0);
        check_val("reset_resp", resp, 8'h00);
        rst      = 1'b0;
        exp_resp = 8'h00;
        exp_rdy  = 1'b0;
        tick();

        send_and_check(16'h23FF, 37, 16'h4002);
        rx_byte(8'hA5, 1'b1);
        send_and_check(16'h0000, 0, 16'h0000);

        rx_drive = 1'b0;
        repeat (4) tick();
        rx_drive = 1'b1;
        repeat (3 * BD) tick();
        exp_rdy = 1'b0;
        check_val("glitch_rdy", resp_rdy, exp_rdy);
        check_val("glitch_resp", resp, exp_resp);
        rx_byte(8'h5A, 1'b0);
        rx_byte(8'h3C, 1'b1);

        for (int n = 0; n < 8; n++) begin
            if ($urandom_range(1, 0) == 1)
                send_and_check(16'($urandom),
                               ($urandom_range(1, 0) == 1) ? int'($urandom_range(20 * BD - 1, 1)) : 0,
                               16'($urandom));
            else
                rx_byte(8'($urandom), $urandom_range(3, 0) != 0);
        end

        loopback = 1'b1;
        cmd      = 16'h6000;
        send_cmd = 1'b1;
        tick();
        send_cmd = 1'b0;
        prev     = resp_rdy;
        for (int t = 0; t < 21 * BD; t++) begin
            tick();
            if (resp_rdy === 1'b1 && prev === 1'b0)
                got_q.push_back(resp);
            prev = resp_rdy;
        end
        check_val("loop_rdy_pulses", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check_val("loop_byte0", got_q[0], 8'h60);
            check_val("loop_byte1", got_q[1], 8'h00);
        end
        check_val("loop_cmd_sent", cmd_sent, 1'b1);

        send_cmd = 1'b1;
        tick();
        send_cmd = 1'b0;
        repeat (15 * BD) tick();
        rst = 1'b1;
        tick();
        check_val("midframe_rst_tx", tx, 1'b1);
        check_val("midframe_rst_cmd_sent", cmd_sent, 1'b0);
        check_val("midframe_rst_rdy", resp_rdy, 1'b0);
        check_val("midframe_rst_resp", resp, 8'h00);
        rst      = 1'b0;
        loopback = 1'b0;
        repeat (2 * BD) tick();
        check_val("post_rst_tx_idle", tx, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
